// File: rtl/dct2d_ctrl_if.sv
// Pixel-side, core-side and result-side signals of the 2-D DCT sequencer.
// master: the environment (pixel source, core, result sink); slave: the sequencer.
interface dct2d_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_row;
   logic [127:0] dct_in;
   logic [95:0]  dct_out;
   logic         out_valid;
   logic [2:0]   out_idx;
   logic [95:0]  out_data;
   logic         busy;
   logic         done;

   modport master (
      output in_valid, in_row, dct_out,
      input  in_ready, dct_in, out_valid, out_idx, out_data, busy, done
   );

   modport slave (
      input  in_valid, in_row, dct_out,
      output in_ready, dct_in, out_valid, out_idx, out_data, busy, done
   );
endinterface

// File: rtl/dct2d_ctrl.sv
// 2-D 8x8 DCT sequencer: rows go through the shared 1-D core into a transpose
// buffer, then buffer columns go through the same core and stream out.
module dct2d_ctrl #(
   parameter int unsigned CORE_LAT = 4
) (
   input logic         clk,
   input logic         rstn,
   dct2d_ctrl_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StRowIn, StRowDrain, StColFeed, StColDrain} state_e;

   state_e       state_q, state_d;
   logic [2:0]   row_cnt_q, row_cnt_d;
   logic [2:0]   col_cnt_q, col_cnt_d;

   // Tag pipeline tracks which issue the core's current output belongs to.
   logic [CORE_LAT-1:0] tag_vld_q;
   logic [CORE_LAT-1:0] tag_col_q;
   logic [2:0]          tag_idx_q [CORE_LAT];

   logic         issue_vld, issue_col;
   logic [2:0]   issue_idx;
   logic         emit_vld, emit_col;
   logic [2:0]   emit_idx;

   logic         in_ready, busy, done;
   logic [127:0] dct_in;

   // Transpose buffer: mem_q[row][col]; contents after reset are don't-care.
   logic [11:0]  mem_q [8][8];

   logic         out_valid_q;
   logic [2:0]   out_idx_q;
   logic [95:0]  out_data_q;

   assign emit_vld = tag_vld_q[CORE_LAT-1];
   assign emit_col = tag_col_q[CORE_LAT-1];
   assign emit_idx = tag_idx_q[CORE_LAT-1];

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.dct_in    = dct_in;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_data  = out_data_q;

   // Next-state, issue and handshake decode.
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      issue_vld = 1'b0;
      issue_col = 1'b0;
      issue_idx = 3'd0;
      dct_in    = '0;
      unique case (state_q)
         StIdle, StRowIn: begin
            busy     = (state_q != StIdle);
            in_ready = 1'b1;
            if (bus.in_valid) begin
               issue_vld = 1'b1;
               issue_idx = row_cnt_q;
               row_cnt_d = row_cnt_q + 3'd1;
               for (int c = 0; c < 8; c++) begin
                  dct_in[16*c +: 16] = {8'h00, bus.in_row[8*c +: 8]};
               end
               state_d = (row_cnt_q == 3'd7) ? StRowDrain : StRowIn;
            end
         end
         StRowDrain: begin
            if (emit_vld && !emit_col && emit_idx == 3'd7) state_d = StColFeed;
         end
         StColFeed: begin
            issue_vld = 1'b1;
            issue_col = 1'b1;
            issue_idx = col_cnt_q;
            col_cnt_d = col_cnt_q + 3'd1;
            for (int j = 0; j < 8; j++) begin
               dct_in[16*j +: 16] = {{4{mem_q[j][col_cnt_q][11]}}, mem_q[j][col_cnt_q]};
            end
            if (col_cnt_q == 3'd7) state_d = StColDrain;
         end
         StColDrain: begin
            if (out_valid_q && out_idx_q == 3'd7) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         row_cnt_q <= 3'd0;
         col_cnt_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
      end
   end

   // Tag shift register, CORE_LAT deep to line up with the core's result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag_vld_q <= '0;
         tag_col_q <= '0;
         for (int i = 0; i < int'(CORE_LAT); i++) tag_idx_q[i] <= 3'd0;
      end else begin
         tag_vld_q[0] <= issue_vld;
         tag_col_q[0] <= issue_col;
         tag_idx_q[0] <= issue_idx;
         for (int i = 1; i < int'(CORE_LAT); i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_col_q[i] <= tag_col_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end

   // Row-pass results land in the transpose buffer row by row.
   always_ff @(posedge clk) begin
      if (emit_vld && !emit_col) begin
         for (int c = 0; c < 8; c++) mem_q[emit_idx][c] <= bus.dct_out[12*c +: 12];
      end
   end

   // Column-pass results are registered straight onto the output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         out_idx_q   <= 3'd0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= emit_vld && emit_col;
         if (emit_vld && emit_col) begin
            out_idx_q  <= emit_idx;
            out_data_q <= bus.dct_out;
         end
      end
   end

endmodule

// File: tb/tb_dct2d_ctrl.sv
// Bench for dct2d_ctrl with an identity stub core (latency LAT).
module tb_dct2d_ctrl;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dct2d_ctrl_if bus ();

   dct2d_ctrl #(.CORE_LAT(LAT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Stub core: out lane c = win lane c [11:0], LAT cycles later.
   logic [95:0] pipe [LAT];
   logic        stub_force = 1'b0;

   function automatic logic [95:0] trunc(input logic [127:0] w);
      logic [95:0] t;
      for (int c = 0; c < 8; c++) t[12*c +: 12] = w[16*c +: 12];
      return t;
   endfunction

   always @(posedge clk) begin
      pipe[0] <= trunc(bus.dct_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign bus.dct_out = stub_force ? {8{12'h800}} : pipe[LAT-1];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mkrow(input int r, input int base);
      logic [63:0] v;
      for (int c = 0; c < 8; c++) v[8*c +: 8] = 8'(base + 8*r + c);
      return v;
   endfunction

   typedef struct {
      int          cyc;
      logic [2:0]  idx;
      logic [95:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];

   // Predictor: on the 8th accepted row, queue the transposed block and its timing.
   initial begin : predictor
      logic [63:0] rows [8];
      int          nrows;
      exp_t        e;
      nrows = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            nrows = 0;
            exp_q.delete();
            done_q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            rows[nrows] = bus.in_row;
            nrows++;
            if (nrows == 8) begin
               for (int k = 0; k < 8; k++) begin
                  e.cyc = cyc + 2*LAT + 2 + k;
                  e.idx = 3'(k);
                  for (int j = 0; j < 8; j++) begin
                     e.data[12*j +: 12] = stub_force ? 12'h800 : {4'h0, rows[j][8*k +: 8]};
                  end
                  exp_q.push_back(e);
               end
               done_q.push_back(cyc + 2*LAT + 9);
               nrows = 0;
            end
         end
      end
   end

   // Monitor: pop and compare whenever the DUT presents a result or done.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_out_valid: got idx %0d, required none (cycle %0d)",
                           bus.out_idx, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("out_cycle", 128'(cyc), 128'(e.cyc));
                  check("out_idx", 128'(bus.out_idx), 128'(e.idx));
                  check("out_data", 128'(bus.out_data), 128'(e.data));
               end
            end
            if (bus.done) begin
               if (done_q.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
               end else begin
                  check("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
               end
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
      check({tag, "_busy"}, 128'(bus.busy), 128'(0));
      check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      check({tag, "_dct_in"}, bus.dct_in, 128'(0));
      check({tag, "_out_idx"}, 128'(bus.out_idx), 128'(0));
      check({tag, "_out_data"}, 128'(bus.out_data), 128'(0));
      check({tag, "_done"}, 128'(bus.done), 128'(0));
   endtask

   // Present one row until accepted; returns the accept cycle. Called at #1 after an edge.
   task automatic send_row(input logic [63:0] row, output int acc);
      bit ok;
      ok  = 1'b0;
      acc = -1;
      bus.in_valid = 1'b1;
      bus.in_row   = row;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok  = 1'b1;
            acc = cyc;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) begin
         nvec++;
         nerr++;
         $display("FAIL accept_timeout: got no accept in 100 cycles, required accept");
      end
   endtask

   task automatic send_block(input int base, input bit gap, output int last);
      for (int r = 0; r < 8; r++) begin
         if (gap && r > 0) begin
            @(posedge clk);
            #1;
         end
         send_row(mkrow(r, base), last);
      end
   endtask

   initial begin : stimulus
      int tl;
      int cnt;
      int dcyc;
      bit seen;
      bit next_chk;
      bus.in_valid = 1'b0;
      bus.in_row   = '0;

      // Reset state, then idle after release.
      repeat (3) begin
         @(negedge clk);
         check_idle("rst");
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_idle("idle");
      end
      @(posedge clk);
      #1;

      // Back-to-back block.
      send_block(0, 1'b0, tl);
      check("busy_after_rows", 128'(bus.busy), 128'(1));
      repeat (24) @(posedge clk);
      #1;

      // Gapped block, same data.
      send_block(0, 1'b1, tl);
      repeat (24) @(posedge clk);
      #1;

      // Sign extension of buffered 12'h800 during COL_FEED.
      stub_force = 1'b1;
      send_block(16, 1'b0, tl);
      do @(negedge clk); while (cyc < tl + LAT);
      check("drain_dct_in", bus.dct_in, 128'(0));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("sext_dct_in", bus.dct_in, {8{16'hF800}});
      end
      repeat (16) @(posedge clk);
      #1 stub_force = 1'b0;

      // Hold-off: in_valid held high for 40 cycles.
      cnt      = 0;
      seen     = 1'b0;
      next_chk = 1'b0;
      dcyc     = 0;
      for (int i = 0; i < 40; i++) begin
         bus.in_valid = 1'b1;
         bus.in_row   = mkrow(cnt % 8, 100 + (cnt / 8) * 30);
         @(negedge clk);
         if (bus.done && !seen) begin
            check("holdoff_rows_before_done", 128'(cnt), 128'(8));
            seen = 1'b1;
            dcyc = cyc;
         end
         if (bus.in_valid && bus.in_ready) begin
            if (seen && !next_chk) begin
               check("holdoff_next_accept", 128'(cyc), 128'(dcyc + 1));
               next_chk = 1'b1;
            end
            cnt++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("holdoff_done_seen", 128'(seen), 128'(1));
      check("holdoff_total_accepts", 128'(cnt), 128'(16));
      repeat (24) @(posedge clk);
      #1;

      // Reset mid COL_FEED (cycle 14 of the block), then a clean block.
      send_block(180, 1'b0, tl);
      repeat (6) @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
      check("midrst_busy", 128'(bus.busy), 128'(0));
      check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      check("midrst_dct_in", bus.dct_in, 128'(0));
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      send_block(40, 1'b0, tl);
      repeat (24) @(posedge clk);
      #1;

      check("exp_queue_empty", 128'(exp_q.size()), 128'(0));
      check("done_queue_empty", 128'(done_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
